div_unit: RTL and testbench

//  Iterative radix-2 restoring divider in the EX stage, serving MIPS DIV/DIVU.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between EX decode and the iterative divider.
// Master drives the operands and control; the divider (slave) returns stall, busy, done and result.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 sign;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cancel;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, sign, a, b, cancel,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, sign, a, b, cancel,
        output stall, busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; result = {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle with the same result value.
//
// state | meaning
// IDLE  | waiting for start; stall asserted combinationally on an accepted start
// RUN   | one restoring step per cycle, WIDTH steps total
// DONE  | one-cycle done pulse, result valid, pipeline released
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_div;
    logic                 r_negq;
    logic                 r_negr;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic [WIDTH:0]       w_shift;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quo_fix;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.cancel;
    assign w_last   = (r_count == CW'(WIDTH - 1));
    assign w_a_neg  = bus.sign && bus.a[WIDTH-1];
    assign w_b_neg  = bus.sign && bus.b[WIDTH-1];
    assign w_a_abs  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_abs  = w_b_neg ? (~bus.b + 1'b1) : bus.b;

    // Partial remainder stays below the divisor, so the WIDTH-bit subtract cannot wrap;
    // with a zero divisor every step subtracts nothing and the dividend shifts into r_rem.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_qbit    = (w_shift >= {1'b0, r_div});
    assign w_rem_nxt = w_qbit ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
    assign w_rem_fix = r_negr ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_quo_fix = r_negq ? (~w_quo_nxt + 1'b1) : w_quo_nxt;

    assign bus.stall  = w_accept || (r_state == RUN);
    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
                    w_state_nxt = (bus.b == '0) ? DONE : RUN;
`else
                    w_state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_abs;
                        r_div   <= w_b_abs;
                        r_negq  <= w_a_neg ^ w_b_neg;
                        r_negr  <= w_a_neg;
`ifdef DIV_ZERO_FAST_EN
                        // Same value the full iteration would produce after sign fix-up.
                        if (bus.b == '0) begin
                            r_result <= {bus.a, (w_a_neg ? WIDTH'(1) : {WIDTH{1'b1}})};
                        end
`endif
                    end
                end
                RUN: begin
                    if (!bus.cancel) begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides push expected results, a monitor checks each done.
// Zero-divisor latency expectation follows DIV_ZERO_FAST_EN.
module tb_div_unit;
    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) u_if ();
    div_unit #(.WIDTH(W)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if)
    );

    logic [63:0] exp_q[$];
    logic [63:0] e_res;
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && u_if.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h, expected no done", u_if.result);
            end else begin
                e_res = exp_q.pop_front();
                chk("result", u_if.result, e_res);
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that leaves DONE.
    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int cyc;
        int stall_cnt;
        bit got;
        cyc = 0; stall_cnt = 0; got = 0;
        u_if.start = 1'b1; u_if.sign = s; u_if.a = a; u_if.b = b; u_if.cancel = 1'b0;
        exp_q.push_back(exp);
        while (cyc < 200 && !got) begin
            @(negedge clk);
            if (u_if.stall === 1'b1) stall_cnt++;
            if (u_if.done === 1'b1) begin
                got = 1;
                chk({name, "_latency"}, 64'(cyc), 64'(lat));
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        u_if.start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done at cycle %0d", name, cyc, lat);
        end else begin
            chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
        end
    endtask

    initial begin
        int d0;
        u_if.start = 1'b0; u_if.sign = 1'b0; u_if.a = '0; u_if.b = '0; u_if.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   64'(u_if.busy),  64'd0);
        chk("rst_done",   64'(u_if.done),  64'd0);
        chk("rst_stall",  64'(u_if.stall), 64'd0);
        chk("rst_result", u_if.result,     64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div("u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                   LAT);
        run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},    LAT);
        run_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},            LAT);
        run_div("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},            LAT);
        run_div("u5_0",     1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF},            ZLAT);
        run_div("s-9_0",    1'b1, 32'hFFFF_FFF7,  32'd0,          {32'hFFFF_FFF7, 32'd1},            ZLAT);
        run_div("u_max_16", 1'b0, 32'hFFFF_FFFF,  32'd16,         {32'd15, 32'h0FFF_FFFF},           LAT);

        // Cancel in RUN: back to IDLE next edge, no done, result held.
        d0 = n_done;
        u_if.start = 1'b1; u_if.sign = 1'b0; u_if.a = 32'd1000; u_if.b = 32'd3; u_if.cancel = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("cancel_busy_before", 64'(u_if.busy), 64'd1);
        u_if.cancel = 1'b1;
        @(posedge clk);
        #1;
        chk("cancel_busy", 64'(u_if.busy), 64'd0);
        chk("cancel_stall", 64'(u_if.stall), 64'd0);
        u_if.start = 1'b0; u_if.cancel = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("cancel_no_done", 64'(n_done - d0), 64'd0);
        chk("cancel_result_hold", u_if.result, {32'd15, 32'h0FFF_FFFF});
        run_div("u1000_3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, LAT);

        // Reset mid-RUN clears everything at once.
        u_if.start = 1'b1; u_if.sign = 1'b0; u_if.a = 32'd1000; u_if.b = 32'd7;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        u_if.start = 1'b0;
        #1;
        chk("mid_rst_stall",  64'(u_if.stall), 64'd0);
        chk("mid_rst_busy",   64'(u_if.busy),  64'd0);
        chk("mid_rst_done",   64'(u_if.done),  64'd0);
        chk("mid_rst_result", u_if.result,     64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d0 = n_done;
        run_div("u50_5",    1'b0, 32'd50,         32'd5, {32'd0, 32'd10},                    LAT);
        run_div("s-100_7",  1'b1, 32'hFFFF_FF9C,  32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2},     LAT);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("b2b_done_count", 64'(n_done - d0), 64'd2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
